// File: rtl/st_buffer.sv
// Store-formatting buffer: lane-aligns store data, builds byte strobes and queues
// word-aligned writes in a FIFO drained to memory. Optional macro: ST_MISALIGN_SPLIT_EN.
module st_buffer #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2:0]              in_funct3,
    input  logic [ADDR_W-1:0]       in_addr,
    input  logic [XLEN-1:0]         in_data,
    output logic                    mem_valid,
    input  logic                    mem_ready,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [XLEN-1:0]         mem_wdata,
    output logic [XLEN/8-1:0]       mem_wstrb,
    output logic                    err,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    empty
);
    localparam int NB    = XLEN / 8;
    localparam int OFFW  = $clog2(NB);
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = PW + 1;
    localparam bit SD_OK = (XLEN == 64);

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              err_q, err_d;

    logic [ADDR_W-1:0] addr_mem_q [DEPTH];
    logic [XLEN-1:0]   data_mem_q [DEPTH];
    logic [NB-1:0]     strb_mem_q [DEPTH];

    logic [OFFW-1:0]   off;
    logic [2*NB-1:0]   mask_w, strb_w;
    logic              illegal, crossing, drop, accept, pop;
    logic [1:0]        push_n;
    logic [ADDR_W-1:0] addr0;
    logic [XLEN-1:0]   data0;
    logic [NB-1:0]     strb0;

    assign off = in_addr[OFFW-1:0];

    always_comb begin
        mask_w = '0;
        case (in_funct3[1:0])
            2'b00:   mask_w = (2*NB)'(8'h01);
            2'b01:   mask_w = (2*NB)'(8'h03);
            2'b10:   mask_w = (2*NB)'(8'h0F);
            default: mask_w = (2*NB)'(8'hFF);
        endcase
    end

    // A store crosses the word exactly when any strobe lands in the upper half
    assign strb_w   = mask_w << off;
    assign crossing = |strb_w[2*NB-1:NB];
    assign illegal  = in_funct3[2] || (!SD_OK && (in_funct3[1:0] == 2'b11));
    assign addr0    = {in_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
    assign strb0    = strb_w[NB-1:0];

`ifdef ST_MISALIGN_SPLIT_EN
    logic [2*XLEN-1:0] data_w;
    logic [ADDR_W-1:0] addr1;
    logic [XLEN-1:0]   data1;
    logic [NB-1:0]     strb1;

    assign data_w   = {{XLEN{1'b0}}, in_data} << {off, 3'b000};
    assign data0    = data_w[XLEN-1:0];
    assign data1    = data_w[2*XLEN-1:XLEN];
    assign addr1    = addr0 + ADDR_W'(NB);
    assign strb1    = strb_w[2*NB-1:NB];
    assign in_ready = (count_q <= CW'(DEPTH - 2));
    assign drop     = illegal;
    assign push_n   = illegal ? 2'd0 : (crossing ? 2'd2 : 2'd1);
`else
    assign data0    = in_data << {off, 3'b000};
    assign in_ready = (count_q != CW'(DEPTH));
    assign drop     = illegal || crossing;
    assign push_n   = drop ? 2'd0 : 2'd1;
`endif

    assign accept = in_valid && in_ready;
    assign pop    = (count_q != '0) && mem_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        err_d    = 1'b0;
        if (accept) begin
            wr_ptr_d = wr_ptr_q + PW'(push_n);
            err_d    = drop;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + (accept ? CW'(push_n) : CW'(0)) - CW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // Payload storage needs no reset; outputs are masked while the FIFO is empty
    always_ff @(posedge clk) begin
        if (accept && (push_n != 2'd0)) begin
            addr_mem_q[wr_ptr_q] <= addr0;
            data_mem_q[wr_ptr_q] <= data0;
            strb_mem_q[wr_ptr_q] <= strb0;
        end
`ifdef ST_MISALIGN_SPLIT_EN
        if (accept && (push_n == 2'd2)) begin
            addr_mem_q[wr_ptr_q + PW'(1)] <= addr1;
            data_mem_q[wr_ptr_q + PW'(1)] <= data1;
            strb_mem_q[wr_ptr_q + PW'(1)] <= strb1;
        end
`endif
    end

    assign empty     = (count_q == '0);
    assign mem_valid = !empty;
    assign count     = count_q;
    assign err       = err_q;
    assign mem_addr  = mem_valid ? addr_mem_q[rd_ptr_q] : '0;
    assign mem_wdata = mem_valid ? data_mem_q[rd_ptr_q] : '0;
    assign mem_wstrb = mem_valid ? strb_mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_st_buffer.sv
// Directed bench for st_buffer (XLEN=32, DEPTH=4); follows ST_MISALIGN_SPLIT_EN if defined.
module tb_st_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, mem_valid, mem_ready, err, empty;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr, in_data, mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_err = 0;

`ifdef ST_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif
    localparam int FILL = SPLIT ? 3 : 4;

    st_buffer #(.XLEN(32), .ADDR_W(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
        .in_addr(in_addr), .in_data(in_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .err(err), .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        in_valid  = 1'b1;
        in_funct3 = f3;
        in_addr   = a;
        in_data   = d;
        step();
        in_valid  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_funct3 = 3'd0; in_addr = '0; in_data = '0; mem_ready = 1'b0;
        step();
        step();
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_count",     32'(count),     32'd0);
        chk("rst_empty",     32'(empty),     32'd1);
        chk("rst_err",       32'(err),       32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_mem_addr",  mem_addr,       32'd0);
        chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        rst = 1'b0;
        step();

        // SB to the top byte lane
        drive(3'b000, 32'h103, 32'h0000_00A5);
        chk("sb_valid", 32'(mem_valid),       32'd1);
        chk("sb_addr",  mem_addr,             32'h100);
        chk("sb_data",  32'(mem_wdata[31:24]), 32'hA5);
        chk("sb_strb",  32'(mem_wstrb),       32'b1000);
        chk("sb_count", 32'(count),           32'd1);
        chk("sb_err",   32'(err),             32'd0);

        // SH to the upper half, then drain both
        drive(3'b001, 32'h202, 32'h0000_F0EE);
        chk("sh_count", 32'(count), 32'd2);
        chk("sh_head_unchanged", mem_addr, 32'h100);
        mem_ready = 1'b1;
        step();
        chk("sh_addr",  mem_addr,              32'h200);
        chk("sh_data",  32'(mem_wdata[31:16]), 32'hF0EE);
        chk("sh_strb",  32'(mem_wstrb),        32'b1100);
        step();
        chk("sh_empty", 32'(empty), 32'd1);
        chk("sh_count0", 32'(count), 32'd0);
        mem_ready = 1'b0;

        // Fill with SW, memory stalled
        for (int i = 0; i < FILL; i++) begin
            drive(3'b010, 32'h400 + 32'(4 * i), 32'hA000_0000 + 32'(i));
        end
        chk("full_count",    32'(count),    32'(FILL));
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_head_addr", mem_addr,     32'h400);
        chk("full_head_data", mem_wdata,    32'hA000_0000);
        chk("full_head_strb", 32'(mem_wstrb), 32'hF);
        // Push while full plus pop: the push must be refused
        in_valid = 1'b1; in_funct3 = 3'b010; in_addr = 32'h500; in_data = 32'hDEAD_BEEF;
        mem_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("full_pushpop_count", 32'(count), 32'(FILL - 1));
        for (int i = 1; i < FILL; i++) begin
            chk("drain_addr", mem_addr,  32'h400 + 32'(4 * i));
            chk("drain_data", mem_wdata, 32'hA000_0000 + 32'(i));
            step();
        end
        chk("drain_empty", 32'(empty), 32'd1);
        mem_ready = 1'b0;

        // Simultaneous push and pop with one entry queued
        drive(3'b010, 32'h600, 32'h0000_0600);
        chk("pp_pre_count", 32'(count), 32'd1);
        in_valid = 1'b1; in_funct3 = 3'b010; in_addr = 32'h604; in_data = 32'h0000_0604;
        mem_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("pp_count", 32'(count), 32'd1);
        chk("pp_addr",  mem_addr,   32'h604);
        chk("pp_data",  mem_wdata,  32'h0000_0604);
        step();
        chk("pp_empty", 32'(empty), 32'd1);
        mem_ready = 1'b0;

        // Illegal stores: SD on a 32-bit datapath, then funct3=100
        drive(3'b011, 32'h0, 32'h1234_5678);
        chk("sd_err",   32'(err),   32'd1);
        chk("sd_count", 32'(count), 32'd0);
        step();
        chk("err_clears", 32'(err), 32'd0);
        drive(3'b100, 32'h0, 32'h1234_5678);
        chk("f100_err",   32'(err),   32'd1);
        chk("f100_count", 32'(count), 32'd0);
        step();

        // Crossing SW at offset 1
        drive(3'b010, 32'h301, 32'h1122_3344);
        if (SPLIT) begin
            chk("split_err",   32'(err),   32'd0);
            chk("split_count", 32'(count), 32'd2);
            chk("split_b0_addr", mem_addr,              32'h300);
            chk("split_b0_strb", 32'(mem_wstrb),        32'b1110);
            chk("split_b0_data", 32'(mem_wdata[31:8]),  32'h22_3344);
            mem_ready = 1'b1;
            step();
            chk("split_b1_addr", mem_addr,              32'h304);
            chk("split_b1_strb", 32'(mem_wstrb),        32'b0001);
            chk("split_b1_data", 32'(mem_wdata[7:0]),   32'h11);
            step();
            chk("split_empty", 32'(empty), 32'd1);
            mem_ready = 1'b0;
        end else begin
            chk("cross_err",   32'(err),   32'd1);
            chk("cross_count", 32'(count), 32'd0);
            chk("cross_empty", 32'(empty), 32'd1);
        end
        step();

        // Asynchronous reset with entries queued
        drive(3'b010, 32'h800, 32'h0000_0800);
        drive(3'b010, 32'h804, 32'h0000_0804);
        if (!SPLIT) drive(3'b010, 32'h808, 32'h0000_0808);
        chk("pre_rst_count", 32'(count), SPLIT ? 32'd2 : 32'd3);
        #2 rst = 1'b1;
        #1;
        chk("arst_mem_valid", 32'(mem_valid), 32'd0);
        chk("arst_count",     32'(count),     32'd0);
        chk("arst_empty",     32'(empty),     32'd1);
        #1 rst = 1'b0;
        step();
        drive(3'b000, 32'h700, 32'h0000_005A);
        chk("post_rst_addr",  mem_addr,             32'h700);
        chk("post_rst_strb",  32'(mem_wstrb),       32'b0001);
        chk("post_rst_data",  32'(mem_wdata[7:0]),  32'h5A);
        chk("post_rst_count", 32'(count),           32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
